// File: rtl/iob_eth_mii_frame_gen_pkg.sv
// Shared constants for the MII frame generator: register map, FSM states, timing, CRC.
// Latency: n/a (package only).
// Backpressure: n/a.
package iob_eth_mii_frame_gen_pkg;

    // Register offsets, decoded on address[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_LEN    = 2'd2;
    localparam logic [1:0] REG_FRAMES = 2'd3;

    // Frame generator states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_FCS  = 3'd4,
        ST_IFG  = 3'd5
    } state_t;

    // Phase lengths in nibble cycles
    localparam int PRE_CYCLES = 14;
    localparam int SFD_CYCLES = 2;
    localparam int FCS_CYCLES = 8;
    localparam int IFG_CYCLES = 24;

    // Line nibbles for preamble and start-of-frame delimiter
    localparam logic [3:0] NIB_PRE = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hD;

    // IEEE 802.3 CRC-32, reflected form
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/iob_eth_mii_frame_gen_if.sv
// IOb native bus between a CPU-side master and the frame generator register/buffer slave.
// Latency: slave answers every request with ready one cycle later.
// Backpressure: none; the slave never inserts wait states.
interface iob_eth_mii_frame_gen_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                valid;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic [DATA_W-1:0]   rdata;
    logic                ready;

    modport master (output valid, address, wdata, wstrb, input rdata, ready);
    modport slave  (input valid, address, wdata, wstrb, output rdata, ready);
endinterface

// File: rtl/iob_eth_crc32_nibble.sv
// Combinational CRC-32 update for one nibble, LSB-first bit order.
// Latency: zero cycles.
// Backpressure: none.
module iob_eth_crc32_nibble
    import iob_eth_mii_frame_gen_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nibble,
    output logic [31:0] crc_out
);

    // Fold the nibble into the low bits, then shift out four bits through the reflected polynomial
    always_comb begin
        crc_out = crc_in ^ {28'd0, nibble};
        for (int i = 0; i < 4; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/iob_eth_mii_frame_gen.sv
// PHY-side MII transmitter replaying a software-loaded frame (preamble, SFD, data, optional FCS, IFG).
// Latency: IOb ready one cycle after valid; first preamble nibble appears with the start acknowledge.
// Backpressure: none; IOb is zero-wait, and buffer/LEN writes are dropped while a frame is in flight.
module iob_eth_mii_frame_gen
    import iob_eth_mii_frame_gen_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int BUF_ADDR_W = 11
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    iob_eth_mii_frame_gen_if.slave        iob,
    output logic [3:0]                    mii_rxd_o,
    output logic                          mii_rx_dv_o,
    output logic                          mii_rx_er_o,
    output logic                          frame_done_o
);

    localparam int CNT_W = BUF_ADDR_W + 1;
    localparam int WORDS = 2 ** (BUF_ADDR_W - 2);

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic [BUF_ADDR_W-1:0]   len_q;
    logic                    crc_en_q;
    logic                    err_q;
    logic                    done_q;
    logic [31:0]             frames_q;
    logic [31:0]             crc_q;
    logic [31:0]             crc_upd;
    logic [31:0]             mem [WORDS];

    logic                    wr;
    logic                    is_buf;
    logic [1:0]              reg_sel;
    logic [BUF_ADDR_W-3:0]   waddr;
    logic                    busy;
    logic                    start_ok;
    logic                    frame_end;
    logic [CNT_W-1:0]        data_last;
    logic [31:0]             word_nx;
    logic [7:0]              byte_nx;
    logic [3:0]              data_nib;
    logic [31:0]             fcs_fin;
    logic [3:0]              rxd_nx;
    logic                    dv_nx;
    logic                    er_nx;
    logic [DATA_W-1:0]       rd_mux;
    logic                    unused_addr;

    assign wr        = iob.valid && (|iob.wstrb);
    assign is_buf    = iob.address[ADDR_W-1];
    assign reg_sel   = iob.address[3:2];
    assign waddr     = iob.address[BUF_ADDR_W-1:2];
    assign busy      = (state != ST_IDLE);
    assign start_ok  = wr && !is_buf && (reg_sel == REG_CTRL) && iob.wdata[0] && !busy && (len_q != '0);
    assign data_last = {len_q, 1'b0} - CNT_W'(1);
    assign unused_addr = ^{iob.address[ADDR_W-2:BUF_ADDR_W], iob.address[1:0]};
    assign frame_done_o = done_q;

    // FSM state and phase counter register
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; cnt counts cycles within the current phase
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + CNT_W'(1);
        frame_end = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nx = '0;
                if (start_ok) state_nx = ST_PRE;
            end
            ST_PRE: if (cnt == CNT_W'(PRE_CYCLES - 1)) begin
                state_nx = ST_SFD;
                cnt_nx   = '0;
            end
            ST_SFD: if (cnt == CNT_W'(SFD_CYCLES - 1)) begin
                state_nx = ST_DATA;
                cnt_nx   = '0;
            end
            ST_DATA: if (cnt == data_last) begin
                state_nx = crc_en_q ? ST_FCS : ST_IFG;
                cnt_nx   = '0;
            end
            ST_FCS: if (cnt == CNT_W'(FCS_CYCLES - 1)) begin
                state_nx = ST_IFG;
                cnt_nx   = '0;
            end
            ST_IFG: if (cnt == CNT_W'(IFG_CYCLES - 1)) begin
                state_nx  = ST_IDLE;
                cnt_nx    = '0;
                frame_end = 1'b1;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Line values for the upcoming cycle, so the MII outputs can be registered without a cycle of lag
    always_comb begin
        word_nx  = mem[cnt_nx[CNT_W-1:3]];
        byte_nx  = word_nx[{cnt_nx[2:1], 3'b000} +: 8];
        data_nib = cnt_nx[0] ? byte_nx[7:4] : byte_nx[3:0];
        fcs_fin  = ~crc_q;
        rxd_nx   = 4'h0;
        dv_nx    = 1'b0;
        er_nx    = 1'b0;
        case (state_nx)
            ST_PRE: begin
                rxd_nx = NIB_PRE;
                dv_nx  = 1'b1;
            end
            ST_SFD: begin
                rxd_nx = (cnt_nx == '0) ? NIB_PRE : NIB_SFD;
                dv_nx  = 1'b1;
            end
            ST_DATA: begin
                rxd_nx = data_nib;
                dv_nx  = 1'b1;
                er_nx  = err_q && (cnt_nx == '0);
            end
            ST_FCS: begin
                rxd_nx = fcs_fin[{cnt_nx[2:0], 2'b00} +: 4];
                dv_nx  = 1'b1;
            end
            default: ;
        endcase
    end

    iob_eth_crc32_nibble u_crc (
        .crc_in  (crc_q),
        .nibble  (data_nib),
        .crc_out (crc_upd)
    );

    // Per-frame state: options latched at start, running CRC, completion flag/counter, MII outputs
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            crc_en_q    <= 1'b0;
            err_q       <= 1'b0;
            crc_q       <= CRC_INIT;
            done_q      <= 1'b0;
            frames_q    <= '0;
            mii_rxd_o   <= 4'h0;
            mii_rx_dv_o <= 1'b0;
            mii_rx_er_o <= 1'b0;
        end else begin
            if (start_ok) begin
                crc_en_q <= iob.wdata[1];
                err_q    <= iob.wdata[2];
                crc_q    <= CRC_INIT;
                done_q   <= 1'b0;
            end else if (state_nx == ST_DATA) begin
                crc_q <= crc_upd;
            end
            if (frame_end) begin
                done_q   <= 1'b1;
                frames_q <= frames_q + 32'd1;
            end
            mii_rxd_o   <= rxd_nx;
            mii_rx_dv_o <= dv_nx;
            mii_rx_er_o <= er_nx;
        end
    end

    // Read data selection for the current request
    always_comb begin
        rd_mux = '0;
        if (is_buf) begin
            rd_mux = mem[waddr];
        end else begin
            case (reg_sel)
                REG_STATUS: rd_mux = {{(DATA_W-2){1'b0}}, done_q, busy};
                REG_LEN:    rd_mux = {{(DATA_W-BUF_ADDR_W){1'b0}}, len_q};
                REG_FRAMES: rd_mux = frames_q;
                default:    rd_mux = '0;
            endcase
        end
    end

    // IOb response and LEN register; LEN is frozen while a frame is in flight
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            iob.ready <= 1'b0;
            iob.rdata <= '0;
            len_q     <= '0;
        end else begin
            iob.ready <= iob.valid;
            iob.rdata <= iob.valid ? rd_mux : '0;
            if (wr && !is_buf && (reg_sel == REG_LEN) && !busy) begin
                len_q <= iob.wdata[BUF_ADDR_W-1:0];
            end
        end
    end

    // Frame buffer byte writes; contents survive reset and are frozen while busy
    always_ff @(posedge clk_i) begin
        if (wr && is_buf && !busy) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (iob.wstrb[b]) mem[waddr][8*b +: 8] <= iob.wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_iob_eth_mii_frame_gen.sv
module tb_iob_eth_mii_frame_gen;

    localparam logic [15:0] A_CTRL   = 16'h0000;
    localparam logic [15:0] A_STATUS = 16'h0004;
    localparam logic [15:0] A_LEN    = 16'h0008;
    localparam logic [15:0] A_FRAMES = 16'h000C;
    localparam logic [15:0] A_BUF    = 16'h8000;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [3:0] rxd;
    logic       dv, er, fdone;

    always #5 clk = ~clk;

    iob_eth_mii_frame_gen_if #(.ADDR_W(16), .DATA_W(32)) iob ();

    iob_eth_mii_frame_gen #(.ADDR_W(16), .DATA_W(32), .BUF_ADDR_W(11)) dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .iob          (iob),
        .mii_rxd_o    (rxd),
        .mii_rx_dv_o  (dv),
        .mii_rx_er_o  (er),
        .frame_done_o (fdone)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_frames = 0;
    logic [7:0]  shadow [2048];
    logic [3:0]  exp_nib [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        iob.valid   = v;
        iob.address = a;
        iob.wdata   = d;
        iob.wstrb   = s;
    endtask

    // Called at a negedge; returns at the negedge where the response is visible
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        drive(1'b1, a, d, s);
        @(negedge clk);
        drive(1'b0, a, 32'd0, 4'd0);
    endtask

    task automatic rd_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
        drive(1'b1, a, 32'd0, 4'd0);
        @(negedge clk);
        drive(1'b0, a, 32'd0, 4'd0);
        check({tag, "_ready"}, 32'(iob.ready), 32'd1);
        check(tag, iob.rdata, exp);
    endtask

    function automatic logic [31:0] shadow_word(input int w);
        return {shadow[4*w+3], shadow[4*w+2], shadow[4*w+1], shadow[4*w]};
    endfunction

    task automatic buf_wr(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) shadow[4*w+b] = d[8*b +: 8];
        wr(A_BUF | 16'(w << 2), d, s);
    endtask

    // Reference frame: preamble, SFD, payload nibbles low-first, optional bytewise CRC-32 LS nibble first
    task automatic build_model(input int len, input bit crc_en);
        logic [31:0] crc;
        exp_nib.delete();
        for (int i = 0; i < 14; i++) exp_nib.push_back(4'h5);
        exp_nib.push_back(4'h5);
        exp_nib.push_back(4'hD);
        crc = 32'hFFFF_FFFF;
        for (int n = 0; n < len; n++) begin
            exp_nib.push_back(shadow[n][3:0]);
            exp_nib.push_back(shadow[n][7:4]);
            crc = crc ^ {24'd0, shadow[n]};
            for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
        end
        if (crc_en) begin
            crc = ~crc;
            for (int k = 0; k < 8; k++) exp_nib.push_back(crc[4*k +: 4]);
        end
    endtask

    task automatic run_frame(input string tag, input int len, input bit crc_en, input bit err, input bit disturb);
        int         e_len;
        int         bad;
        int         first;
        int         dv_cnt;
        logic [5:0] obs_v, exp_v, first_obs, first_exp;
        build_model(len, crc_en);
        e_len = exp_nib.size();
        bad = 0; first = -1; dv_cnt = 0;
        first_obs = '0; first_exp = '0;
        wr(A_CTRL, {29'd0, err, crc_en, 1'b1}, 4'hF);
        for (int i = 0; i < e_len + 24; i++) begin
            obs_v = {er, dv, rxd};
            exp_v = {(err && i == 16), (i < e_len), (i < e_len) ? exp_nib[i] : 4'h0};
            if (dv) dv_cnt++;
            if (obs_v !== exp_v) begin
                bad++;
                if (first < 0) begin
                    first = i; first_obs = obs_v; first_exp = exp_v;
                end
            end
            if (i == e_len + 23) check({tag, "_done_before_ifg_end"}, 32'(fdone), 32'd0);
            if (disturb) begin
                case (i)
                    20: drive(1'b1, A_CTRL, 32'd1, 4'hF);
                    21: drive(1'b1, A_BUF, 32'h0000_00FF, 4'h1);
                    22: drive(1'b1, A_LEN, 32'd1, 4'hF);
                    23: drive(1'b1, A_STATUS, 32'd0, 4'h0);
                    24: begin
                        check({tag, "_status_busy"}, iob.rdata, 32'd1);
                        drive(1'b0, A_CTRL, 32'd0, 4'h0);
                    end
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        check($sformatf("%s_bad_cycles(first@%0d er/dv/rxd %0h vs %0h)", tag, first, first_obs, first_exp),
              32'(bad), 32'd0);
        check({tag, "_dv_cycles"}, 32'(dv_cnt), 32'(e_len));
        exp_frames++;
        check({tag, "_frame_done"}, 32'(fdone), 32'd1);
        rd_check({tag, "_status"}, A_STATUS, 32'd2);
        rd_check({tag, "_frames"}, A_FRAMES, 32'(exp_frames));
    endtask

    initial begin
        int any_dv;
        int len;
        drive(1'b0, 16'd0, 32'd0, 4'd0);
        for (int i = 0; i < 2048; i++) shadow[i] = 8'h00;

        // Reset state while reset is held
        #2;
        check("rst_rxd", 32'(rxd), 32'd0);
        check("rst_dv", 32'(dv), 32'd0);
        check("rst_er", 32'(er), 32'd0);
        check("rst_ready", 32'(iob.ready), 32'd0);
        check("rst_rdata", iob.rdata, 32'd0);
        check("rst_done", 32'(fdone), 32'd0);
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        rd_check("init_status", A_STATUS, 32'd0);
        rd_check("init_len", A_LEN, 32'd0);
        rd_check("init_frames", A_FRAMES, 32'd0);

        // Start with LEN=0 is ignored
        wr(A_CTRL, 32'd1, 4'hF);
        any_dv = 0;
        for (int i = 0; i < 40; i++) begin
            if (dv) any_dv++;
            @(negedge clk);
        end
        check("len0_dv_cycles", 32'(any_dv), 32'd0);
        rd_check("len0_status", A_STATUS, 32'd0);

        // "123456789" with FCS: check value CBF43926
        buf_wr(0, 32'h3433_3231, 4'hF);
        buf_wr(1, 32'h3837_3635, 4'hF);
        buf_wr(2, 32'h0000_0039, 4'hF);
        wr(A_LEN, 32'd9, 4'hF);
        rd_check("len9_readback", A_LEN, 32'd9);
        run_frame("crc9", 9, 1'b1, 1'b0, 1'b0);

        // Single byte 0xAB, no FCS; partial-strobe write keeps other bytes
        buf_wr(0, 32'h0000_00AB, 4'h1);
        rd_check("strb_word0", A_BUF, shadow_word(0));
        wr(A_LEN, 32'd1, 4'hF);
        run_frame("len1", 1, 1'b0, 1'b0, 1'b0);

        // Error injection on the first DATA cycle only
        buf_wr(0, $urandom, 4'hF);
        wr(A_LEN, 32'd4, 4'hF);
        run_frame("err4", 4, 1'b0, 1'b1, 1'b0);

        // Restart, buffer write and LEN write mid-frame are all ignored
        run_frame("disturb", 4, 1'b1, 1'b0, 1'b1);
        rd_check("disturb_word0", A_BUF, shadow_word(0));
        rd_check("disturb_len", A_LEN, 32'd4);

        // Random payloads and options
        for (int t = 0; t < 4; t++) begin
            len = int'($urandom_range(1, 24));
            for (int w = 0; w < (len + 3) / 4; w++) buf_wr(w, $urandom, 4'hF);
            wr(A_LEN, 32'(len), 4'hF);
            run_frame($sformatf("rand%0d_len%0d", t, len), len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Asynchronous reset during DATA
        buf_wr(0, $urandom, 4'hF);
        wr(A_LEN, 32'd4, 4'hF);
        wr(A_CTRL, 32'd3, 4'hF);
        repeat (20) @(negedge clk);
        #2 arst = 1'b1;
        #1;
        check("arst_dv_now", 32'(dv), 32'd0);
        check("arst_rxd_now", 32'(rxd), 32'd0);
        check("arst_ready_now", 32'(iob.ready), 32'd0);
        #1 arst = 1'b0;
        @(negedge clk);
        exp_frames = 0;
        rd_check("arst_status", A_STATUS, 32'd0);
        rd_check("arst_frames", A_FRAMES, 32'd0);
        rd_check("arst_len", A_LEN, 32'd0);
        rd_check("arst_buf_kept", A_BUF, shadow_word(0));
        wr(A_LEN, 32'd4, 4'hF);
        run_frame("after_arst", 4, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_eth_mii_frame_gen.md
IOB_ETH_MII_FRAME_GEN -- requirements
Module: iob_eth_mii_frame_gen

Interface
REQ-001 Parameter ADDR_W, default 16, IOb slave byte-address width.
REQ-002 Parameter DATA_W, default 32, IOb data width; only 32 is supported.
REQ-003 Parameter BUF_ADDR_W, default 11, frame-buffer byte-address width (2048 bytes).
REQ-004 clk_i  input  1  single clock; frame generation runs on this clock, one nibble per cycle.
REQ-005 arst_i  input  1  reset; asynchronous and active-high.
REQ-006 valid  input  1  IOb request strobe.
REQ-007 address  input  ADDR_W  IOb byte address.
REQ-008 wdata  input  DATA_W  IOb write data.
REQ-009 wstrb  input  DATA_W/8  IOb byte enables; all-zero means read.
REQ-010 rdata  output  DATA_W  IOb read data, valid while ready is high.
REQ-011 ready  output  1  IOb response, registered.
REQ-012 mii_rxd_o  output  4  MII receive nibble toward the MAC.
REQ-013 mii_rx_dv_o  output  1  MII receive data valid.
REQ-014 mii_rx_er_o  output  1  MII receive error.
REQ-015 frame_done_o  output  1  equals STATUS.done.

Function
REQ-016 The block is the PHY-side MII transmitter that feeds a MAC receive path from a software-loaded frame buffer.
REQ-017 Every request with valid=1 gets ready=1 on the next cycle, with rdata registered in that same cycle; there are no wait states.
REQ-018 Address map, selected by address[ADDR_W-1]:
- address[ADDR_W-1]=0: register file, decoded on address[3:2].
  - 0x0 CTRL (write-only): bit0 start (self-clearing), bit1 crc_en, bit2 err_inject.
  - 0x4 STATUS (read-only): bit0 busy, bit1 done.
  - 0x8 LEN (read/write): [BUF_ADDR_W-1:0], frame length in bytes.
  - 0xC FRAMES (read-only): 32-bit count of completed frames, wraps at 2^32.
- address[ADDR_W-1]=1: buffer word address[BUF_ADDR_W-1:2], honouring wstrb.
REQ-019 Buffer byte order is little-endian: byte n is word n/4, bits [8*(n%4)+7 : 8*(n%4)].
REQ-020 Buffer reads always return the stored word.
REQ-021 While busy, buffer writes and LEN writes are ignored; ready still responds.
REQ-022 FSM states are IDLE, PRE, SFD, DATA, FCS and IFG.
REQ-023 IDLE -> PRE on a CTRL write with bit0=1 when LEN!=0; done clears at the same time.
REQ-024 A start written while busy, or while LEN=0, is ignored.
REQ-025 PRE lasts 14 cycles with mii_rxd_o=0x5.
REQ-026 SFD lasts 2 cycles with mii_rxd_o=0x5, then 0xD.
REQ-027 DATA lasts 2*LEN cycles, low nibble of each byte first.
REQ-028 FCS lasts 8 cycles when crc_en=1 and is skipped otherwise.
REQ-029 IFG lasts 24 cycles with mii_rx_dv_o=0; at its end the FSM returns to IDLE, sets done and increments FRAMES.
REQ-030 mii_rx_dv_o=1 exactly during PRE, SFD, DATA and FCS.
REQ-031 mii_rxd_o=0 whenever mii_rx_dv_o=0.
REQ-032 MII outputs are registered; the first PRE nibble appears in the same cycle that ready acknowledges the start write.
REQ-033 FCS is IEEE 802.3 CRC-32 computed over the DATA bytes only:
- reflected polynomial 0xEDB88320, init 0xFFFFFFFF, final complement;
- updated one nibble per DATA cycle;
- emitted least-significant nibble first.
REQ-034 With err_inject=1, mii_rx_er_o=1 for the first DATA cycle only; otherwise mii_rx_er_o=0.
REQ-035 CTRL crc_en and err_inject are sampled at start and held for the whole frame.
REQ-036 busy=1 in every state except IDLE.

Reset
REQ-037 On arst_i, without waiting for a clock edge:
- mii_rxd_o=0, mii_rx_dv_o=0, mii_rx_er_o=0, ready=0, rdata=0;
- state=IDLE, CTRL=0, LEN=0, done=0, FRAMES=0;
- an in-flight frame is abandoned, with rx_dv dropping immediately.
REQ-038 Buffer contents are not reset.

Structure
REQ-039 Shared package iob_eth_mii_frame_gen_pkg holds:
- register offsets;
- FSM state encoding;
- PRE/SFD/FCS/IFG cycle counts;
- nibble constants 0x5 and 0xD;
- CRC polynomial and init value.
REQ-040 One sub-module, iob_eth_crc32_nibble, holds the combinational nibble CRC update: inputs crc_in[31:0] and nibble[3:0], output crc_out[31:0].

Verification
REQ-041 Buffer loaded with 0x34333231, 0x38373635, 0x00000039; LEN=9; CTRL=0x3 -> nibbles 5 x14, 5, D, 1,3,2,3,...,9,3, then FCS nibbles 6,2,9,3,4,F,B,C (CRC 0xCBF43926); rx_dv high for exactly 42 cycles, then 24 low; done=1, FRAMES=1.
REQ-042 LEN=1, byte 0xAB, CTRL=0x1 -> rx_dv high 18 cycles, data nibbles B then A, no FCS.
REQ-043 CTRL=0x1 with LEN=0 -> no rx_dv activity; STATUS reads 0.
REQ-044 Second start mid-frame, plus a buffer write to byte 0 mid-frame -> the frame is unchanged, no restart, and the buffer write is dropped.
REQ-045 CTRL=0x5, LEN=4 -> rx_er high only on the first DATA cycle.
REQ-046 arst_i pulse during DATA -> rx_dv=0 at once, STATUS=0 and FRAMES=0 after release; a subsequent start transmits a correct frame.
